// File: rtl/uart_cmd_pkg.sv
// Shared types and default protocol codes for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    GET_CHK  = 3'd3,
    EXEC     = 3'd4,
    RD_WAIT  = 3'd5,
    SEND     = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h55;
  localparam logic [7:0] ACK_DEFAULT  = 8'h06;
  localparam logic [7:0] NAK_DEFAULT  = 8'h15;

endpackage

// File: rtl/uart_cmd_ctrl_rx_byte_fetch.sv
// Consumes one byte per rx_valid assertion; the ack and the byte strobe share a cycle.
module rx_byte_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ack,
  output logic       byte_strobe,
  output logic [7:0] byte_data
);

  logic       ack_pending_reg;
  logic       strobe_reg;
  logic [7:0] data_reg;
  logic       fetch;

  // ack_pending blocks a re-fetch while the receiver still holds the acked byte
  assign fetch = active && rx_valid && !ack_pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pending_reg <= 1'b0;
      strobe_reg      <= 1'b0;
      data_reg        <= 8'h00;
    end else begin
      strobe_reg <= fetch;
      if (fetch) begin
        ack_pending_reg <= 1'b1;
        data_reg        <= rx_data;
      end else if (!rx_valid) begin
        ack_pending_reg <= 1'b0;
      end
    end
  end

  assign rx_ack      = strobe_reg;
  assign byte_strobe = strobe_reg;
  assign byte_data   = data_reg;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed register-access command sequencer: SYNC, ADDR, DATA, CHK in; one response byte out.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 50000,
  parameter logic [7:0] ACK_BYTE  = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE  = NAK_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ack,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [7:0]    addr_reg, data_reg;
  logic [CW-1:0] to_cnt_reg;
  logic [7:0]    tx_data_next;
  logic          fetch_active, timed, timeout_hit, chk_ok;
  logic          byte_strobe, err_inc, load_cmd;
  logic [7:0]    byte_data;

  assign fetch_active = (state_reg == IDLE) || timed;
  assign timed        = (state_reg == GET_ADDR) || (state_reg == GET_DATA) || (state_reg == GET_CHK);
  // a fetched byte clears the counter, so it always takes priority over timeout
  assign timeout_hit  = timed && !byte_strobe && (to_cnt_reg == CW'(TIMEOUT - 1));
  assign chk_ok       = (byte_data == (SYNC_BYTE ^ addr_reg ^ data_reg));

  rx_byte_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .active     (fetch_active),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .byte_strobe(byte_strobe),
    .byte_data  (byte_data)
  );

  always_comb begin
    state_next   = state_reg;
    tx_data_next = tx_data;
    err_inc      = 1'b0;
    load_cmd     = 1'b0;
    case (state_reg)
      IDLE:     if (byte_strobe && byte_data == SYNC_BYTE) state_next = GET_ADDR;
      GET_ADDR: if (byte_strobe) state_next = GET_DATA;
                else if (timeout_hit) begin state_next = IDLE; err_inc = 1'b1; end
      GET_DATA: if (byte_strobe) state_next = GET_CHK;
                else if (timeout_hit) begin state_next = IDLE; err_inc = 1'b1; end
      GET_CHK: begin
        if (byte_strobe) begin
          if (chk_ok) begin
            state_next = EXEC;
            load_cmd   = 1'b1;
          end else begin
            state_next   = SEND;
            tx_data_next = NAK_BYTE;
            err_inc      = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          err_inc    = 1'b1;
        end
      end
      EXEC: begin
        if (addr_reg[7]) begin
          state_next = RD_WAIT;
        end else begin
          state_next   = SEND;
          tx_data_next = ACK_BYTE;
        end
      end
      RD_WAIT: begin
        state_next   = SEND;
        tx_data_next = reg_rdata;
      end
      SEND:    if (tx_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= 8'h00;
      data_reg   <= 8'h00;
      to_cnt_reg <= '0;
      reg_addr   <= 7'h00;
      reg_wdata  <= 8'h00;
      tx_data    <= 8'h00;
      err_cnt    <= 8'h00;
    end else begin
      state_reg <= state_next;
      tx_data   <= tx_data_next;
      if (state_reg == GET_ADDR && byte_strobe) addr_reg <= byte_data;
      if (state_reg == GET_DATA && byte_strobe) data_reg <= byte_data;
      // reg_addr/reg_wdata are loaded on EXEC entry and otherwise hold
      if (load_cmd) begin
        reg_addr  <= addr_reg[6:0];
        reg_wdata <= data_reg;
      end
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (!timed || byte_strobe || state_next != state_reg) to_cnt_reg <= '0;
      else                                                  to_cnt_reg <= to_cnt_reg + CW'(1);
    end
  end

  assign reg_we   = (state_reg == EXEC) && !addr_reg[7];
  assign reg_re   = (state_reg == EXEC) && addr_reg[7];
  assign tx_valid = (state_reg == SEND);
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: write/read/bad-checksum/noise/timeout/stall/reset frames.
module tb_uart_cmd_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] err_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0, ack_cnt = 0, ack_cyc = 0, we_cnt = 0, we_cyc = 0, re_cnt = 0;
  int tv_cnt = 0, tx_cnt = 0;
  logic [6:0] we_addr = 7'h00, re_addr = 7'h00;
  logic [7:0] we_data = 8'h00, tx_last = 8'h00;

  uart_cmd_ctrl #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // register bank: read data valid only in the cycle after reg_re
  always @(posedge clk) reg_rdata <= reg_re ? 8'h3C : 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (rx_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (reg_we) begin we_cnt++; we_cyc = cyc; we_addr = reg_addr; we_data = reg_wdata; end
    if (reg_re) begin re_cnt++; re_addr = reg_addr; end
    if (tx_valid) tv_cnt++;
    if (tx_valid && tx_ready) begin tx_cnt++; tx_last = tx_data; end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL rx_ack_wait byte=%02h: no ack within 200 cycles", b);
    end
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b, expected 0", name, busy);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int hold);
    send_byte(8'h55, hold);
    send_byte(a, hold);
    send_byte(d, hold);
    send_byte(c, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ack, reg_we, reg_re, tx_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack/we/re/tv/busy=%b expected 00000", {rx_ack, reg_we, reg_re, tx_valid, busy});
    end
    checks++;
    if (reg_addr !== 7'h00 || reg_wdata !== 8'h00 || tx_data !== 8'h00 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h tx=%h err=%h expected all 0", reg_addr, reg_wdata, tx_data, err_cnt);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset: checked outputs cleared");
  endtask

  task automatic test_write();
    int we0, tv0, tx0;
    we0 = we_cnt; tv0 = tv_cnt; tx0 = tx_cnt;
    send_frame(8'h12, 8'hA7, 8'hE0, 0);
    wait_idle("write");
    checks++;
    if (we_cnt - we0 != 1 || we_addr !== 7'h12 || we_data !== 8'hA7) begin
      errors++;
      $display("FAIL write_strobe: we=%0d addr=%h data=%h expected 1/12/A7", we_cnt - we0, we_addr, we_data);
    end
    checks++;
    if (we_cyc - ack_cyc != 1) begin
      errors++;
      $display("FAIL write_latency: %0d cycles from CHK ack, expected 1", we_cyc - ack_cyc);
    end
    checks++;
    if (tx_cnt - tx0 != 1 || tx_last !== 8'h06 || tv_cnt - tv0 != 1) begin
      errors++;
      $display("FAIL write_resp: tx=%0d data=%h tv_cycles=%0d expected 1/06/1", tx_cnt - tx0, tx_last, tv_cnt - tv0);
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL write_err: err_cnt=%h expected 00", err_cnt);
    end
    $display("write: 55 12 A7 E0 -> we addr=%h data=%h resp=%h", we_addr, we_data, tx_last);
  endtask

  task automatic test_read();
    int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    send_frame(8'h85, 8'h00, 8'hD0, 0);
    wait_idle("read");
    checks++;
    if (re_cnt - re0 != 1 || re_addr !== 7'h05 || we_cnt != we0) begin
      errors++;
      $display("FAIL read_strobe: re=%0d addr=%h we=%0d expected 1/05/0", re_cnt - re0, re_addr, we_cnt - we0);
    end
    checks++;
    if (tx_last !== 8'h3C) begin
      errors++;
      $display("FAIL read_resp: tx=%h expected 3C", tx_last);
    end
    $display("read: 55 85 00 D0 -> re addr=%h resp=%h", re_addr, tx_last);
  endtask

  task automatic test_bad_chk();
    int we0;
    we0 = we_cnt;
    send_frame(8'h12, 8'hA7, 8'h00, 0);
    wait_idle("badchk");
    checks++;
    if (we_cnt != we0 || tx_last !== 8'h15 || err_cnt !== 8'h01) begin
      errors++;
      $display("FAIL badchk: we=%0d tx=%h err=%h expected 0/15/01", we_cnt - we0, tx_last, err_cnt);
    end
    $display("bad_chk: 55 12 A7 00 -> resp=%h err_cnt=%h", tx_last, err_cnt);
  endtask

  task automatic test_noise();
    int a0, we0;
    a0 = ack_cnt; we0 = we_cnt;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hAA, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (ack_cnt - a0 != 3 || busy !== 1'b0 || err_cnt !== 8'h01) begin
      errors++;
      $display("FAIL noise: acks=%0d busy=%b err=%h expected 3/0/01", ack_cnt - a0, busy, err_cnt);
    end
    send_frame(8'h34, 8'h56, 8'h37, 0);
    wait_idle("noise");
    checks++;
    if (we_cnt - we0 != 1 || we_addr !== 7'h34 || we_data !== 8'h56 || tx_last !== 8'h06) begin
      errors++;
      $display("FAIL noise_write: we=%0d addr=%h data=%h tx=%h expected 1/34/56/06", we_cnt - we0, we_addr, we_data, tx_last);
    end
    $display("noise: 00 FF AA discarded, then write addr=%h data=%h", we_addr, we_data);
  endtask

  task automatic test_timeout();
    int we0, re0, tv0;
    we0 = we_cnt; re0 = re_cnt; tv0 = tv_cnt;
    send_byte(8'h55, 0);
    send_byte(8'h12, 0);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: busy=%b one cycle before limit, expected 1", busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err_cnt !== 8'h02 || tv_cnt != tv0 || we_cnt != we0 || re_cnt != re0) begin
      errors++;
      $display("FAIL timeout: busy=%b err=%h tv=%0d we=%0d re=%0d expected 0/02/0/0/0",
               busy, err_cnt, tv_cnt - tv0, we_cnt - we0, re_cnt - re0);
    end
    send_frame(8'h01, 8'h02, 8'h56, 0);
    wait_idle("timeout");
    checks++;
    if (we_cnt - we0 != 1 || we_addr !== 7'h01 || we_data !== 8'h02) begin
      errors++;
      $display("FAIL timeout_recover: we=%0d addr=%h data=%h expected 1/01/02", we_cnt - we0, we_addr, we_data);
    end
    $display("timeout: err_cnt=%h, recovery write addr=%h", err_cnt, we_addr);
  endtask

  task automatic test_slow_rx();
    int a0, we0;
    a0 = ack_cnt; we0 = we_cnt;
    send_frame(8'h40, 8'h99, 8'h8C, 3);
    wait_idle("slow");
    checks++;
    if (ack_cnt - a0 != 4 || we_cnt - we0 != 1 || we_addr !== 7'h40 || we_data !== 8'h99) begin
      errors++;
      $display("FAIL slow_rx: acks=%0d we=%0d addr=%h data=%h expected 4/1/40/99", ack_cnt - a0, we_cnt - we0, we_addr, we_data);
    end
    $display("slow_rx: 4 bytes held 3 cycles -> acks=%0d", ack_cnt - a0);
  endtask

  task automatic test_tx_stall();
    int n, bad, tx0;
    tx0 = tx_cnt;
    tx_ready = 1'b0;
    send_frame(8'h12, 8'hA7, 8'hE0, 0);
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tx_stall_hold: %0d of 10 cycles lost tx_valid/tx_data, expected 0", bad);
    end
    tx_ready = 1'b1;
    wait_idle("stall");
    checks++;
    if (tx_cnt - tx0 != 1 || tx_last !== 8'h06) begin
      errors++;
      $display("FAIL tx_stall_release: tx=%0d data=%h expected 1/06", tx_cnt - tx0, tx_last);
    end
    $display("tx_stall: response held 10 cycles then accepted data=%h", tx_last);
  endtask

  task automatic test_reset_mid_send();
    int n, we0, tv0;
    tx_ready = 1'b0;
    send_frame(8'h12, 8'hA7, 8'hE0, 0);
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_send: tx_valid=%b busy=%b expected 0/0", tx_valid, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    we0 = we_cnt; tv0 = tv_cnt;
    tx_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (tv_cnt != tv0 || we_cnt != we0 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rst_after: tv=%0d we=%0d err=%h expected 0/0/00", tv_cnt - tv0, we_cnt - we0, err_cnt);
    end
    $display("reset_mid_send: response dropped, err_cnt=%h", err_cnt);
  endtask

  initial begin
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_bad_chk();
    test_noise();
    test_timeout();
    test_slow_rx();
    test_tx_stall();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer downstream of the UART receiver.
- Consumes received bytes over the rx valid/ack handshake and parses framed register-access commands (SYNC, ADDR, DATA, CHK).
- Issues single-cycle register write/read strobes to a local register bank and returns a one-byte response over a valid/ready handshake to the UART transmitter.
- Tracks protocol errors: bad checksum and inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker; also the checksum seed.
- TIMEOUT, 50000, maximum clk cycles allowed between consecutive bytes of a frame.
- ACK_BYTE, 8'h06, response byte for a successful write.
- NAK_BYTE, 8'h15, response byte for a checksum failure.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte, valid while rx_valid=1
- rx_valid  in  1  byte available; held by the receiver until acked
- rx_ack  out  1  one-cycle consume pulse to the receiver
- reg_addr  out  7  register address (ADDR[6:0])
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- tx_data  out  8  response byte
- tx_valid  out  1  response available
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&tx_ready
- err_cnt  out  8  saturating count of checksum and timeout errors
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE. rx_ack, reg_we, reg_re, tx_valid and busy are 0. reg_addr, reg_wdata, tx_data and err_cnt are 0. The timeout counter and the ack_pending flag are cleared.
- Byte fetch rule, active in IDLE, GET_ADDR, GET_DATA and GET_CHK:
  - If rx_valid=1 and ack_pending=0: pulse rx_ack for 1 cycle, latch rx_data and set ack_pending.
  - ack_pending clears on the first cycle rx_valid=0. This prevents double-consuming a byte, because the receiver drops rx_valid one cycle after the ack.
  - The latched byte is acted on in the same cycle the ack is issued.
- States and transitions:
  - IDLE: a fetched byte equal to SYNC_BYTE goes to GET_ADDR. Any other byte is discarded silently (no error count).
  - GET_ADDR: store the byte as ADDR. ADDR[7]=0 means write, 1 means read. Go to GET_DATA.
  - GET_DATA: store the byte as DATA (don't-care for reads, but still included in the checksum). Go to GET_CHK.
  - GET_CHK:
    - If byte == SYNC_BYTE^ADDR^DATA, go to EXEC.
    - Otherwise load tx_data=NAK_BYTE, increment err_cnt and go to SEND.
  - EXEC, write: reg_addr=ADDR[6:0], reg_wdata=DATA, reg_we=1 for exactly 1 cycle. Load tx_data=ACK_BYTE and go to SEND.
  - EXEC, read: reg_addr=ADDR[6:0], reg_re=1 for 1 cycle. Go to RD_WAIT.
  - RD_WAIT: capture reg_rdata into tx_data. Go to SEND.
  - SEND: tx_valid=1 with tx_data stable until tx_ready=1. On the handshake cycle go to IDLE, and tx_valid drops the next cycle.
- Latency: from the CHK byte ack to the reg_we pulse is 1 cycle. Read data is captured 2 cycles after the CHK ack.
- Timeout (GET_ADDR/GET_DATA/GET_CHK only):
  - The counter clears on entry to each of these states and on every fetched byte, and increments every other cycle.
  - When the counter reaches TIMEOUT-1: go to IDLE, increment err_cnt, send no response, assert no strobe.
  - Counter width is $clog2(TIMEOUT+1).
- err_cnt saturates at 8'hFF; no wrap.
- Bytes arriving during EXEC, RD_WAIT or SEND are not acked. rx_valid stays high, and the byte is fetched after returning to IDLE (treated as a sync hunt).
- Timeout and checksum failure on the same cycle cannot occur: a fetch clears the counter first, so the checksum result wins.
- Reset mid-frame or mid-SEND aborts immediately. Any pending response is dropped, and no strobe is issued afterwards.
- reg_addr and reg_wdata hold their last values outside EXEC.

Decomposition:
- Package uart_cmd_pkg holds the state enum (IDLE, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, SEND) and default codes for SYNC, ACK and NAK.
- Sub-module rx_byte_fetch is natural: ack_pending flag plus rx_ack pulse generation, with a "byte_strobe" output to the FSM.

Test Plan:
- Write frame 55,12,A7,E0 with tx_ready=1:
  - one reg_we pulse with reg_addr=0x12 and reg_wdata=0xA7;
  - tx_data=0x06 with tx_valid for 1 cycle;
  - err_cnt=0.
- Read frame 55,85,00,D0 with reg_rdata=0x3C driven 1 cycle after reg_re:
  - reg_re pulse with addr=0x05;
  - tx_data=0x3C;
  - no reg_we.
- Bad checksum 55,12,A7,00:
  - no reg_we;
  - tx_data=0x15;
  - err_cnt=1.
- Noise bytes 00,FF,AA before a valid write frame:
  - noise consumed with one rx_ack each and err_cnt stays 0;
  - write then executes normally.
- Send 55,12, then idle for TIMEOUT cycles:
  - return to IDLE;
  - err_cnt=1, no tx_valid, no strobe.
  - A following complete frame executes correctly.
- Hold rx_valid=1 for 3 cycles per byte, and separately hold tx_ready=0 for 10 cycles in SEND:
  - exactly one rx_ack per byte;
  - tx_data stable and tx_valid held throughout.
  - Assert rst mid-SEND: tx_valid=0 immediately.
